// File: rtl/result_arbiter_pkg.sv
// Shared constants and state encoding for the result arbiter.
package result_arbiter_pkg;

    localparam int N_CORES         = 16;
    localparam int IDX_W           = 4;
    localparam int SCORE_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT  = 136;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Index of the core after idx, wrapping 15 -> 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/result_arbiter_word_to_bit.sv
// word_to_bit: binary index to one-hot decoder with enable.
module word_to_bit #(
    parameter int WORD_W = 4
) (
    input  logic [WORD_W-1:0]      word_i,
    input  logic                   en_i,
    output logic [(1<<WORD_W)-1:0] bit_o
);

    // One-hot decode of word_i, all zeros when disabled.
    always_comb begin
        bit_o = '0;
        if (en_i) begin
            bit_o[word_i] = 1'b1;
        end
    end

endmodule

// File: rtl/result_arbiter.sv
// result_arbiter: round-robin arbiter sharing one result path among 16 hash
// cores. Optional macro RESULT_ARBITER_BEST_FILTER_EN drops results that do
// not strictly improve on the best score forwarded so far.
module result_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int SCORE_W = SCORE_W_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CORES-1:0]        req_valid_i,
    input  logic [N_CORES*DATA_W-1:0] req_data_i,
    output logic [N_CORES-1:0]        req_ack_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [IDX_W-1:0]          out_idx_o,
    output logic [SCORE_W-1:0]        best_score_o,
    output logic                      busy_o
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [SCORE_W-1:0]  best_q, best_d;
    logic [N_CORES-1:0]  ack_q, ack_d;

    logic                found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;
    logic [DATA_W-1:0]   sel_data;
    logic                drop;
    logic                ack_en;
    logic [IDX_W-1:0]    ack_idx;
    logic [SCORE_W-1:0]  out_score;

    // Round-robin search: first valid core at ptr, ptr+1, ... wrapping.
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_q;
        cand    = ptr_q;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && req_valid_i[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Selected core's result word and the drop decision for it.
    always_comb begin
        sel_data = req_data_i[sel_idx*DATA_W +: DATA_W];
`ifdef RESULT_ARBITER_BEST_FILTER_EN
        drop = (sel_data[SCORE_W-1:0] >= best_q);
`else
        drop = 1'b0;
`endif
    end

    assign out_score = out_data_q[SCORE_W-1:0];

    // Next-state and next-output logic for the IDLE/SEND/ACK sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        best_d      = best_q;
        ack_en      = 1'b0;
        ack_idx     = grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = sel_idx;
                    // A dropped result skips SEND; its ack is raised on
                    // entry to ACK exactly like a forwarded one.
                    if (drop) begin
                        state_d = ST_ACK;
                        ptr_d   = next_idx(sel_idx);
                        ack_en  = 1'b1;
                        ack_idx = sel_idx;
                    end else begin
                        state_d     = ST_SEND;
                        out_valid_d = 1'b1;
                        out_data_d  = sel_data;
                        out_idx_d   = sel_idx;
                    end
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_ready_i) begin
                    state_d     = ST_ACK;
                    out_valid_d = 1'b0;
                    ptr_d       = next_idx(grant_q);
                    best_d      = (out_score < best_q) ? out_score : best_q;
                    ack_en      = 1'b1;
                    ack_idx     = grant_q;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    word_to_bit #(
        .WORD_W (IDX_W)
    ) u_ack_dec (
        .word_i (ack_idx),
        .en_i   (ack_en),
        .bit_o  (ack_d)
    );

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            best_q      <= '1;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            best_q      <= best_d;
            ack_q       <= ack_d;
        end
    end

    assign req_ack_o    = ack_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_idx_o    = out_idx_q;
    assign best_score_o = best_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_result_arbiter.sv
// Directed self-checking bench for result_arbiter.
module tb_result_arbiter;
    import result_arbiter_pkg::*;

    localparam int DW = 136;
    localparam int SW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       req_valid = '0;
    logic [16*DW-1:0]  req_data = '0;
    logic [15:0]       req_ack;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_idx;
    logic [SW-1:0]     best_score;
    logic              busy;

    int errors = 0;
    int checks = 0;

    result_arbiter #(
        .DATA_W  (DW),
        .SCORE_W (SW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ack_o    (req_ack),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_idx_o    (out_idx),
        .best_score_o (best_score),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input int k, input int s);
        logic [7:0] t;
        t = 8'(k) ^ 8'h5A;
        return {54'h0, 64'hDEAD_BEEF_0000_0000 | 64'(k), t, 10'(s)};
    endfunction

    task automatic set_core(input int k, input int s);
        req_data[k*DW +: DW] = mk(k, s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until an ack appears (bounded); reports whether out_valid was seen.
    task automatic wait_ack(output logic [15:0] ack, output bit saw_valid, output int cycles);
        ack = '0;
        saw_valid = 0;
        cycles = 0;
        while (cycles < 20) begin
            step();
            cycles++;
            if (out_valid) saw_valid = 1;
            if (req_ack != 16'h0) begin
                ack = req_ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 16'hFFFF;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        checks++; if (req_ack !== 16'h0) begin errors++; $display("FAIL rst_ack: got %h want 0000", req_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
        checks++; if (best_score !== 10'h3FF) begin errors++; $display("FAIL rst_best: got %h want 3ff", best_score); end
        req_valid = '0;
        out_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        set_core(0, 123);
        req_valid = 16'h0001;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL basic_idx: got %0d want 0", out_idx); end
        checks++; if (out_data !== mk(0, 123)) begin errors++; $display("FAIL basic_data: got %h want %h", out_data, mk(0, 123)); end
        checks++; if (req_ack !== 16'h0) begin errors++; $display("FAIL basic_early_ack: got %h want 0000", req_ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", busy); end
        step();
        checks++; if (req_ack !== 16'h0001) begin errors++; $display("FAIL basic_ack: got %h want 0001", req_ack); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_ack: got %0b want 0", out_valid); end
        checks++; if (best_score !== 10'd123) begin errors++; $display("FAIL basic_best: got %0d want 123", best_score); end
        req_valid = '0;
        step();
        checks++; if (req_ack !== 16'h0) begin errors++; $display("FAIL basic_ack_len: got %h want 0000", req_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int exp;
        do_reset();
        for (int k = 0; k < 16; k++) set_core(k, 500 - k);
        out_ready = 1'b1;
        req_valid = 16'hFFFF;
        for (int g = 0; g <= 16; g++) begin
            exp = g % 16;
            cyc = 0;
            while (!out_valid && cyc < 10) begin
                step();
                cyc++;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_timeout: grant %0d got no valid within %0d cycles", g, cyc);
            end else if (out_idx !== 4'(exp) || out_data !== mk(exp, (g == 16) ? 10 : 500 - exp)) begin
                errors++; $display("FAIL rr_grant: grant %0d got idx %0d data %h want idx %0d", g, out_idx, out_data, exp);
            end
            if (g > 0) begin
                checks++; if (cyc !== 2) begin errors++; $display("FAIL rr_rate: grant %0d got gap %0d want 3", g, cyc + 1); end
            end
            step();
            checks++; if (req_ack !== (16'h1 << exp)) begin errors++; $display("FAIL rr_ack: grant %0d got %h want %h", g, req_ack, 16'h1 << exp); end
            if (g == 15) set_core(0, 10);
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        logic [15:0] ack;
        bit saw;
        int cyc;
        do_reset();
        out_ready = 1'b1;
        set_core(0, 300);
        set_core(15, 200);
        req_valid = 16'h0001;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h0001 || !saw) begin errors++; $display("FAIL wrap_first: got ack %h valid %0b want 0001 1", ack, saw); end
        set_core(0, 100);
        req_valid = 16'h8001;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h8000 || !saw) begin errors++; $display("FAIL wrap_15: got ack %h valid %0b want 8000 1", ack, saw); end
        req_valid = 16'h0001;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h0001 || !saw) begin errors++; $display("FAIL wrap_0: got ack %h valid %0b want 0001 1", ack, saw); end
        checks++; if (out_idx !== 4'd0 || out_data !== mk(0, 100)) begin errors++; $display("FAIL wrap_data: got idx %0d data %h want 0 %h", out_idx, out_data, mk(0, 100)); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_core(2, 50);
        req_valid = 16'h0004;
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd2) begin errors++; $display("FAIL bp_start: got valid %0b idx %0d want 1 2", out_valid, out_idx); end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'd2 || out_data !== mk(2, 50) || req_ack !== 16'h0) begin
                errors++; $display("FAIL bp_hold: cycle %0d got valid %0b idx %0d ack %h data %h", c, out_valid, out_idx, req_ack, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        checks++; if (req_ack !== 16'h0004 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got ack %h valid %0b want 0004 0", req_ack, out_valid); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        out_ready = 1'b1;
        set_core(5, 900);
        req_valid = 16'h0020;
        step();
        step();
        checks++; if (req_ack !== 16'h0020) begin errors++; $display("FAIL rms_pre_ack: got %h want 0020", req_ack); end
        out_ready = 1'b0;
        set_core(3, 77);
        set_core(7, 60);
        req_valid = 16'h0088;
        step();
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd7) begin errors++; $display("FAIL rms_grant7: got valid %0b idx %0d want 1 7", out_valid, out_idx); end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_valid: got %0b want 0", out_valid); end
        checks++; if (req_ack !== 16'h0) begin errors++; $display("FAIL rms_ack: got %h want 0000", req_ack); end
        checks++; if (best_score !== 10'h3FF) begin errors++; $display("FAIL rms_best: got %h want 3ff", best_score); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy: got %0b want 0", busy); end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3 || out_data !== mk(3, 77)) begin errors++; $display("FAIL rms_regrant: got valid %0b idx %0d want 1 3", out_valid, out_idx); end
        step();
        checks++; if (req_ack !== 16'h0008) begin errors++; $display("FAIL rms_ack_after: got %h want 0008", req_ack); end
        req_valid = '0;
    endtask

    task automatic test_scores();
        logic [15:0] ack;
        bit saw;
        int cyc;
        bit exp_fwd;
`ifdef RESULT_ARBITER_BEST_FILTER_EN
        exp_fwd = 0;
`else
        exp_fwd = 1;
`endif
        do_reset();
        out_ready = 1'b1;
        set_core(1, 400);
        req_valid = 16'h0002;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h0002 || saw !== 1'b1) begin errors++; $display("FAIL sc_400: got ack %h fwd %0b want 0002 1", ack, saw); end
        checks++; if (best_score !== 10'd400) begin errors++; $display("FAIL sc_best400: got %0d want 400", best_score); end
        set_core(2, 500);
        req_valid = 16'h0004;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h0004 || saw !== exp_fwd) begin errors++; $display("FAIL sc_500: got ack %h fwd %0b want 0004 %0b", ack, saw, exp_fwd); end
        checks++; if (best_score !== 10'd400) begin errors++; $display("FAIL sc_best500: got %0d want 400", best_score); end
        set_core(3, 350);
        req_valid = 16'h0008;
        wait_ack(ack, saw, cyc);
        checks++; if (ack !== 16'h0008 || saw !== 1'b1) begin errors++; $display("FAIL sc_350: got ack %h fwd %0b want 0008 1", ack, saw); end
        checks++; if (best_score !== 10'd350) begin errors++; $display("FAIL sc_best350: got %0d want 350", best_score); end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid_send();
        test_scores();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
